// File: rtl/video_signal_generator.sv
// Raster timing generator: pixel/line counters, syncs, data enable, frame strobe and frame counter.
// Every output is registered from next-state values so it lines up with o_sx/o_sy on the same cycle.
module video_signal_generator #(
    parameter int H_ACTIVE          = 640,
    parameter int H_FP              = 16,
    parameter int H_SYNC            = 96,
    parameter int H_BP              = 48,
    parameter int V_ACTIVE          = 480,
    parameter int V_FP              = 10,
    parameter int V_SYNC            = 2,
    parameter int V_BP              = 33,
    parameter int SYNC_POL          = 0,
    parameter int FRAMES_PER_SECOND = 60,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int SXW     = $clog2(H_TOTAL),
    localparam int SYW     = $clog2(V_TOTAL),
    localparam int FCW     = $clog2(FRAMES_PER_SECOND)
) (
    input  logic           i_clk_pxl,
    input  logic           i_reset_n,
    output logic [SXW-1:0] o_sx,
    output logic [SYW-1:0] o_sy,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_de,
    output logic           o_nf,
    output logic [FCW-1:0] o_fc
);

    localparam logic           SYNC_ACT = (SYNC_POL != 0);
    localparam logic [SXW-1:0] SX_LAST  = SXW'(H_TOTAL - 1);
    localparam logic [SYW-1:0] SY_LAST  = SYW'(V_TOTAL - 1);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAMES_PER_SECOND - 1);

    // One extra bit so thresholds equal to the total (empty porches) still compare correctly
    localparam logic [SXW:0] H_VIS   = (SXW+1)'(H_ACTIVE);
    localparam logic [SXW:0] HS_BEG  = (SXW+1)'(H_ACTIVE + H_FP);
    localparam logic [SXW:0] HS_END  = (SXW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [SYW:0] V_VIS   = (SYW+1)'(V_ACTIVE);
    localparam logic [SYW:0] VS_BEG  = (SYW+1)'(V_ACTIVE + V_FP);
    localparam logic [SYW:0] VS_END  = (SYW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [SXW-1:0] sx_nxt;
    logic [SYW-1:0] sy_nxt;
    logic [FCW-1:0] fc_nxt;
    logic           hs_nxt;
    logic           vs_nxt;
    logic           de_nxt;
    logic           nf_nxt;
    logic [SXW:0]   sx_ext;
    logic [SYW:0]   sy_ext;

    always_comb begin
        sx_nxt = o_sx + SXW'(1);
        sy_nxt = o_sy;
        fc_nxt = o_fc;
        if (o_sx == SX_LAST) begin
            sx_nxt = '0;
            if (o_sy == SY_LAST) begin
                sy_nxt = '0;
                fc_nxt = (o_fc == FC_LAST) ? '0 : o_fc + FCW'(1);
            end else begin
                sy_nxt = o_sy + SYW'(1);
            end
        end
    end

    // Decode on the coordinates that will be presented next cycle
    always_comb begin
        sx_ext = {1'b0, sx_nxt};
        sy_ext = {1'b0, sy_nxt};
        de_nxt = (sx_ext < H_VIS) && (sy_ext < V_VIS);
        hs_nxt = ((sx_ext >= HS_BEG) && (sx_ext < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
        vs_nxt = ((sy_ext >= VS_BEG) && (sy_ext < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
        nf_nxt = (sx_nxt == SX_LAST) && (sy_nxt == SY_LAST);
    end

    always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sx    <= '0;
            o_sy    <= '0;
            o_fc    <= '0;
            o_de    <= 1'b1;
            o_hsync <= ~SYNC_ACT;
            o_vsync <= ~SYNC_ACT;
            o_nf    <= 1'b0;
        end else begin
            o_sx    <= sx_nxt;
            o_sy    <= sy_nxt;
            o_fc    <= fc_nxt;
            o_de    <= de_nxt;
            o_hsync <= hs_nxt;
            o_vsync <= vs_nxt;
            o_nf    <= nf_nxt;
        end
    end

endmodule

// File: tb/tb_video_signal_generator.sv
// Bench for video_signal_generator on a shrunken raster; expected outputs come from the
// elapsed-clock count since reset release, decomposed into column, line and frame.
module tb_video_signal_generator;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 2;
    localparam int FPS = 4;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;
    localparam int SXW = $clog2(HT);
    localparam int SYW = $clog2(VT);
    localparam int FCW = $clog2(FPS);

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic           hsync, vsync, de, nf;
    logic [FCW-1:0] fc;

    int unsigned t;
    int total  = 0;
    int passes = 0;
    int hs_low, vs_low, nf_cnt;

    always #5 clk = ~clk;

    video_signal_generator #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0), .FRAMES_PER_SECOND(FPS)
    ) dut (
        .i_clk_pxl(clk), .i_reset_n(rst_n),
        .o_sx(sx), .o_sy(sy), .o_hsync(hsync), .o_vsync(vsync),
        .o_de(de), .o_nf(nf), .o_fc(fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
    endtask

    // Reference: position within the raster is just the clock count since release
    task automatic check_model();
        int x, y, f;
        x = int'(t % HT);
        y = int'((t / HT) % VT);
        f = int'((t / FT) % FPS);
        chk("sx", 32'(sx), 32'(x));
        chk("sy", 32'(sy), 32'(y));
        chk("fc", 32'(fc), 32'(f));
        chk("de", 32'(de), 32'(x < HA && y < VA));
        chk("hsync", 32'(hsync), 32'(!(x >= HA + HFP && x < HA + HFP + HS)));
        chk("vsync", 32'(vsync), 32'(!(y >= VA + VFP && y < VA + VFP + VS)));
        chk("nf", 32'(nf), 32'(x == HT - 1 && y == VT - 1));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            check_model();
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (nf) nf_cnt++;
        end
    endtask

    // Called at a falling edge; asserts reset mid-cycle and releases on a falling edge
    task automatic reset_pulse(input int cycles);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        t = 0;
        check_model();
        repeat (cycles) begin
            @(negedge clk);
            check_model();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        reset_pulse(3);

        hs_low = 0; vs_low = 0; nf_cnt = 0;
        run(1);
        chk("first_sx", 32'(sx), 32'd1);
        run(HT - 1);
        chk("line_hs_low", 32'(hs_low), 32'(HS));
        chk("line_wrap_sy", 32'(sy), 32'd1);
        run(FT - HT);
        chk("frame_hs_low", 32'(hs_low), 32'(HS * VT));
        chk("frame_vs_low", 32'(vs_low), 32'(VS * HT));
        chk("frame_nf_cnt", 32'(nf_cnt), 32'd1);
        chk("frame_fc1", 32'(fc), 32'd1);

        run(FT);
        chk("fc_two_frames", 32'(fc), 32'd2);
        nf_cnt = 0;
        run(3 * FT);
        chk("fc_wrapped", 32'(fc), 32'd1);
        chk("nf_three_frames", 32'(nf_cnt), 32'd3);

        run(2 * FT + 5 * HT + 10);
        chk("mid_sx", 32'(sx), 32'd10);
        chk("mid_sy", 32'(sy), 32'd5);
        chk("mid_fc", 32'(fc), 32'd3);
        reset_pulse(2);
        chk("rst_fc", 32'(fc), 32'd0);
        run(FT + 5);

        for (int i = 0; i < 12; i++) begin
            run($urandom_range(1, 2 * FT));
            if ($urandom_range(0, 2) == 0) reset_pulse($urandom_range(0, 3));
        end
        run(HT);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
